trigger_sequencer: RTL and testbench
====================================

# trigger_sequencer

Programmable trigger sequencer on the `clkin` register bus driven by `cmd_handler`. When armed, it waits for a single-cycle edge event from the edge-detect path. It then drives `trigger_out` with a train of pulses whose delay, width, count and gap are all configured over UART. This block owns trigger timing: the edge detector only reports events, and the sequencer decides when and how the trigger fires.

## Interface
- `CMD_BASE`, default 8'h10: base `reg_cmd` value. Registers sit at `CMD_BASE+0` through `CMD_BASE+4`.
- `DELAY_W`, default 32: width of the delay counter. Legal range is 8–32; the register is `DELAY_W/8` bytes wide.
- `clkin`, input, 1: the single clock for all logic.
- `reset`, input, 1: synchronous, active-high.
- `reg_cmd`, input, 8: register address from `cmd_handler`.
- `reg_bytecount`, input, 16: byte index within the register, little-endian (0 selects bits 7:0).
- `reg_data_in`, input, 8: write byte. Valid when `reg_write` is high.
- `reg_write`, input, 1: one-cycle write strobe.
- `reg_read`, input, 1: one-cycle read strobe. Does not affect state.
- `data_read`, output, 8: read data for the addressed register and byte. Combinational; 0 for unmapped addresses and bytes.
- `event_in`, input, 1: one-cycle edge event, already synchronous to `clkin`.
- `trigger_out`, output, 1: registered trigger pulse output.
- `armed`, `busy`, `done`, output, 1 each: registered status bits, also suitable for LEDs.

## Operation
- **Register map** (an out-of-range bytecount is ignored on write and reads 0):
  - +0 CTRL, write, 1 byte: bit0 ARM, bit1 ABORT. Reads return STATUS.
  - +1 DELAY, `DELAY_W/8` bytes: cycles from event to first pulse.
  - +2 WIDTH, 2 bytes: pulse high time in cycles. 0 is treated as 1.
  - +3 COUNT, 1 byte: pulses per arm. 0 is treated as 1.
  - +4 GAP, 2 bytes: low cycles between pulses. 0 is treated as 1.
  - STATUS = {5'b0, `done`, `busy`, `armed`}.
- **Reset values:** DELAY = 0, WIDTH = 1, COUNT = 1, GAP = 0. State is IDLE. `trigger_out`, `armed`, `busy` and `done` are all 0.
- **States:** IDLE, ARMED, DELAY, PULSE, GAP.
  - IDLE: an ARM write goes to ARMED, sets `armed`, and clears `done`.
  - ARMED: `event_in` latches DELAY, WIDTH, COUNT and GAP into shadow registers. `armed` clears, `busy` sets, and the FSM goes to DELAY.
  - DELAY: counts the shadow delay, then goes to PULSE.
  - PULSE: `trigger_out` is high for the shadow WIDTH cycles. The remaining-pulse count is decremented at PULSE exit. If pulses remain, go to GAP; otherwise go to IDLE with `busy` cleared and `done` set.
  - GAP: `trigger_out` is low for the shadow GAP cycles, then goes to PULSE. The FSM does not wait for a new event between pulses.
- **Config writes** are accepted in every state. A sequence in progress uses only its shadow copies; new values take effect on the next event.
- **ARM** written in ARMED, DELAY, PULSE or GAP is ignored.
- **ABORT** works from any state:
  - Next cycle: state IDLE, `trigger_out` 0, `armed` 0, `busy` 0, `done` 0.
  - If ARM and ABORT are written in the same byte, ABORT wins.
- **`event_in`** outside ARMED is ignored and is not queued. An event in the same cycle as the ARM write is also ignored, because the FSM is not yet ARMED.
- **Reset mid-sequence** returns everything to reset values on the next edge, including the config registers.
- **Counter rules:**
  - The delay counter is `DELAY_W` bits and does not wrap; the maximum delay is 2^`DELAY_W`−1.
  - The width and gap counters are 16 bits.
  - The pulse counter is 8 bits.

## Timing
- **Register write:** a write strobe on cycle t makes the register visible on `data_read` at t+1.
- **ARM:** written on cycle t, `armed` is 1 at t+1.
- **Event to pulse:** an event sampled on cycle e makes `trigger_out` rise at e+1+DELAY. With DELAY = 0 it rises at e+1.
- **Pulse shape:**
  - High for exactly max(WIDTH,1) cycles.
  - Low for exactly max(GAP,1) cycles between pulses.
  - Last pulse falling edge at e+1+DELAY+N·W+(N−1)·G, where W = max(WIDTH,1), G = max(GAP,1) and N is the pulse count. `done` rises in the same cycle.
- **`busy`** is high from e+1 until the last pulse's falling-edge cycle.
- **ABORT:** `trigger_out` falls one cycle after the strobe.

## Test plan
- **Reset defaults:** apply reset, read +0 through +4 → STATUS 0x00, DELAY 0, WIDTH 1, COUNT 1, GAP 0.
- **Single pulse:**
  - Stimulus: DELAY = 10, WIDTH = 3, COUNT = 1, ARM, then `event_in` at cycle e.
  - Response: `trigger_out` is high on cycles e+11..e+13; `done` = 1 at e+14; STATUS = 0x04.
- **Pulse train:**
  - Stimulus: DELAY = 0, WIDTH = 2, COUNT = 3, GAP = 4, event at e.
  - Response: pulses at e+1..2, e+7..8 and e+13..14. A second event at e+5 produces no extra pulse.
- **Zero handling:** WIDTH = 0, COUNT = 0, GAP = 0 → exactly one pulse, 1 cycle wide.
- **Abort and ignored ARM:**
  - Stimulus: abort during PULSE.
  - Response: `trigger_out` is 0 next cycle and STATUS = 0x00. A subsequent event without ARM gives no pulse.
  - Separately: ARM+ABORT in one write → remains IDLE; ARM while busy → no effect.
- **Shadowing:** write DELAY = 50 during DELAY of a DELAY = 20 sequence → the current pulse still occurs at e+21, and the next armed sequence uses 50.

Source files
------------

// File: rtl/trigger_sequencer.sv
// Programmable trigger sequencer: after ARM, an event launches a train of
// pulses with configurable delay, width, count and gap on trigger_out.
module trigger_sequencer #(
  parameter logic [7:0] CMD_BASE = 8'h10,
  parameter int         DELAY_W  = 32
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic [7:0]  reg_cmd,
  input  logic [15:0] reg_bytecount,
  input  logic [7:0]  reg_data_in,
  input  logic        reg_write,
  input  logic        reg_read,
  output logic [7:0]  data_read,
  input  logic        event_in,
  output logic        trigger_out,
  output logic        armed,
  output logic        busy,
  output logic        done,
  output logic [2:0]  o_dbg_state
);

  localparam int         DELAY_BYTES = DELAY_W / 8;
  localparam logic [7:0] A_CTRL  = CMD_BASE;
  localparam logic [7:0] A_DELAY = CMD_BASE + 8'd1;
  localparam logic [7:0] A_WIDTH = CMD_BASE + 8'd2;
  localparam logic [7:0] A_COUNT = CMD_BASE + 8'd3;
  localparam logic [7:0] A_GAP   = CMD_BASE + 8'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // Live configuration registers
  logic [DELAY_W-1:0] r_delay;
  logic [15:0]        r_width;
  logic [7:0]         r_count;
  logic [15:0]        r_gap;

  // Sequence state and shadow copies
  state_t             r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_dly_cnt, w_dly_cnt_nxt;
  logic [15:0]        r_tmr, w_tmr_nxt;
  logic [7:0]         r_pulses, w_pulses_nxt;
  logic [15:0]        r_sh_width, w_sh_width_nxt;
  logic [15:0]        r_sh_gap, w_sh_gap_nxt;
  logic               r_trig, w_trig_nxt;
  logic               r_armed, w_armed_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic        w_wr_ctrl;
  logic        w_arm;
  logic        w_abort;
  logic [15:0] w_width_eff;
  logic [15:0] w_gap_eff;
  logic [7:0]  w_count_eff;
  logic [31:0] w_delay_pad;
  logic        w_unused_read;

  assign w_wr_ctrl   = reg_write && (reg_cmd == A_CTRL) && (reg_bytecount == 16'd0);
  assign w_arm       = w_wr_ctrl && reg_data_in[0];
  assign w_abort     = w_wr_ctrl && reg_data_in[1];
  assign w_width_eff = (r_width == 16'd0) ? 16'd1 : r_width;
  assign w_gap_eff   = (r_gap == 16'd0) ? 16'd1 : r_gap;
  assign w_count_eff = (r_count == 8'd0) ? 8'd1 : r_count;
  assign w_delay_pad = 32'(r_delay);
  // Reads have no side effects, so the strobe is not needed.
  assign w_unused_read = reg_read;

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_delay <= '0;
      r_width <= 16'd1;
      r_count <= 8'd1;
      r_gap   <= 16'd0;
    end else if (reg_write) begin
      case (reg_cmd)
        A_DELAY: begin
          for (int b = 0; b < DELAY_BYTES; b++) begin
            if (reg_bytecount == 16'(b)) r_delay[8*b +: 8] <= reg_data_in;
          end
        end
        A_WIDTH: begin
          if (reg_bytecount == 16'd0)      r_width[7:0]  <= reg_data_in;
          else if (reg_bytecount == 16'd1) r_width[15:8] <= reg_data_in;
        end
        A_COUNT: begin
          if (reg_bytecount == 16'd0) r_count <= reg_data_in;
        end
        A_GAP: begin
          if (reg_bytecount == 16'd0)      r_gap[7:0]  <= reg_data_in;
          else if (reg_bytecount == 16'd1) r_gap[15:8] <= reg_data_in;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_read = 8'h00;
    case (reg_cmd)
      A_CTRL: begin
        if (reg_bytecount == 16'd0) data_read = {5'b0, r_done, r_busy, r_armed};
      end
      A_DELAY: begin
        if (reg_bytecount < 16'(DELAY_BYTES)) data_read = w_delay_pad[8*reg_bytecount[1:0] +: 8];
      end
      A_WIDTH: begin
        if (reg_bytecount == 16'd0)      data_read = r_width[7:0];
        else if (reg_bytecount == 16'd1) data_read = r_width[15:8];
      end
      A_COUNT: begin
        if (reg_bytecount == 16'd0) data_read = r_count;
      end
      A_GAP: begin
        if (reg_bytecount == 16'd0)      data_read = r_gap[7:0];
        else if (reg_bytecount == 16'd1) data_read = r_gap[15:8];
      end
      default: data_read = 8'h00;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dly_cnt  <= '0;
      r_tmr      <= 16'd0;
      r_pulses   <= 8'd0;
      r_sh_width <= 16'd1;
      r_sh_gap   <= 16'd1;
      r_trig     <= 1'b0;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dly_cnt  <= w_dly_cnt_nxt;
      r_tmr      <= w_tmr_nxt;
      r_pulses   <= w_pulses_nxt;
      r_sh_width <= w_sh_width_nxt;
      r_sh_gap   <= w_sh_gap_nxt;
      r_trig     <= w_trig_nxt;
      r_armed    <= w_armed_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Counters hold "cycles remaining after this one", so a zero count means
  // the current cycle is the last in that phase.
  always_comb begin
    w_state_nxt    = r_state;
    w_dly_cnt_nxt  = r_dly_cnt;
    w_tmr_nxt      = r_tmr;
    w_pulses_nxt   = r_pulses;
    w_sh_width_nxt = r_sh_width;
    w_sh_gap_nxt   = r_sh_gap;
    w_trig_nxt     = r_trig;
    w_armed_nxt    = r_armed;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;

    case (r_state)
      S_IDLE: begin
        if (w_arm) begin
          w_state_nxt = S_ARMED;
          w_armed_nxt = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end
      S_ARMED: begin
        if (event_in) begin
          w_sh_width_nxt = w_width_eff;
          w_sh_gap_nxt   = w_gap_eff;
          w_pulses_nxt   = w_count_eff;
          w_armed_nxt    = 1'b0;
          w_busy_nxt     = 1'b1;
          if (r_delay == '0) begin
            // Zero delay skips the DELAY phase so the pulse starts at e+1.
            w_state_nxt = S_PULSE;
            w_tmr_nxt   = w_width_eff - 16'd1;
            w_trig_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_DELAY;
            w_dly_cnt_nxt = r_delay - DELAY_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (r_dly_cnt == '0) begin
          w_state_nxt = S_PULSE;
          w_tmr_nxt   = r_sh_width - 16'd1;
          w_trig_nxt  = 1'b1;
        end else begin
          w_dly_cnt_nxt = r_dly_cnt - DELAY_W'(1);
        end
      end
      S_PULSE: begin
        if (r_tmr == 16'd0) begin
          w_trig_nxt   = 1'b0;
          w_pulses_nxt = r_pulses - 8'd1;
          if (r_pulses <= 8'd1) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
            w_tmr_nxt   = r_sh_gap - 16'd1;
          end
        end else begin
          w_tmr_nxt = r_tmr - 16'd1;
        end
      end
      S_GAP: begin
        if (r_tmr == 16'd0) begin
          w_state_nxt = S_PULSE;
          w_tmr_nxt   = r_sh_width - 16'd1;
          w_trig_nxt  = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides everything, including an ARM in the same byte.
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_trig_nxt  = 1'b0;
      w_armed_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  assign trigger_out = r_trig;
  assign armed       = r_armed;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: register access, pulse timing,
// zero handling, abort, ignored ARM/event, shadowing and mid-run reset.
module tb_trigger_sequencer;

  localparam logic [7:0] A_CTRL  = 8'h10;
  localparam logic [7:0] A_DELAY = 8'h11;
  localparam logic [7:0] A_WIDTH = 8'h12;
  localparam logic [7:0] A_COUNT = 8'h13;
  localparam logic [7:0] A_GAP   = 8'h14;

  logic        clkin;
  logic        reset;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic        reg_write;
  logic        reg_read;
  logic [7:0]  data_read;
  logic        event_in;
  logic        trigger_out;
  logic        armed;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int          n_tests;
  int          n_fail;
  logic [63:0] tr_trig;
  logic [63:0] tr_busy;
  logic [63:0] tr_done;
  logic [7:0]  rd_val;

  trigger_sequencer #(.CMD_BASE(8'h10), .DELAY_W(32)) dut (
    .clkin         (clkin),
    .reset         (reset),
    .reg_cmd       (reg_cmd),
    .reg_bytecount (reg_bytecount),
    .reg_data_in   (reg_data_in),
    .reg_write     (reg_write),
    .reg_read      (reg_read),
    .data_read     (data_read),
    .event_in      (event_in),
    .trigger_out   (trigger_out),
    .armed         (armed),
    .busy          (busy),
    .done          (done),
    .o_dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] bc, input logic [7:0] data);
    reg_cmd       = addr;
    reg_bytecount = bc;
    reg_data_in   = data;
    reg_write     = 1'b1;
    tick();
    reg_write     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [15:0] bc, output logic [7:0] data);
    reg_cmd       = addr;
    reg_bytecount = bc;
    reg_read      = 1'b1;
    #1;
    data          = data_read;
    reg_read      = 1'b0;
  endtask

  task automatic fire_event();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
  endtask

  // Records outputs for n cycles; trace bit i is the cycle i cycles from now.
  task automatic capture(input int n, input int ev_idx);
    tr_trig = '0;
    tr_busy = '0;
    tr_done = '0;
    for (int i = 0; i < n; i++) begin
      event_in   = (i == ev_idx);
      tr_trig[i] = trigger_out;
      tr_busy[i] = busy;
      tr_done[i] = done;
      tick();
    end
    event_in = 1'b0;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    reg_cmd       = 8'h00;
    reg_bytecount = 16'd0;
    reg_data_in   = 8'h00;
    reg_write     = 1'b0;
    reg_read      = 1'b0;
    event_in      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset defaults
    chk("rst_trig", 64'(trigger_out), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    rd(A_CTRL, 16'd0, rd_val);  chk("rst_status", 64'(rd_val), 64'h00);
    rd(A_DELAY, 16'd0, rd_val); chk("rst_delay0", 64'(rd_val), 64'h00);
    rd(A_DELAY, 16'd3, rd_val); chk("rst_delay3", 64'(rd_val), 64'h00);
    rd(A_WIDTH, 16'd0, rd_val); chk("rst_width0", 64'(rd_val), 64'h01);
    rd(A_WIDTH, 16'd1, rd_val); chk("rst_width1", 64'(rd_val), 64'h00);
    rd(A_COUNT, 16'd0, rd_val); chk("rst_count", 64'(rd_val), 64'h01);
    rd(A_GAP, 16'd0, rd_val);   chk("rst_gap", 64'(rd_val), 64'h00);

    // Multi-byte DELAY, out-of-range bytes ignored and read as 0
    wr(A_DELAY, 16'd0, 8'h11);
    wr(A_DELAY, 16'd1, 8'h22);
    wr(A_DELAY, 16'd2, 8'h33);
    wr(A_DELAY, 16'd3, 8'h44);
    wr(A_DELAY, 16'd4, 8'h55);
    rd(A_DELAY, 16'd1, rd_val); chk("delay_b1", 64'(rd_val), 64'h22);
    rd(A_DELAY, 16'd3, rd_val); chk("delay_b3", 64'(rd_val), 64'h44);
    rd(A_DELAY, 16'd4, rd_val); chk("delay_b4_oob", 64'(rd_val), 64'h00);
    rd(A_COUNT, 16'd1, rd_val); chk("count_b1_oob", 64'(rd_val), 64'h00);
    rd(8'h20, 16'd0, rd_val);   chk("unmapped", 64'(rd_val), 64'h00);
    for (int b = 0; b < 4; b++) wr(A_DELAY, 16'(b), 8'h00);

    // Single pulse; an event coincident with ARM is ignored
    wr(A_DELAY, 16'd0, 8'd10);
    wr(A_WIDTH, 16'd0, 8'd3);
    wr(A_COUNT, 16'd0, 8'd1);
    event_in = 1'b1;
    wr(A_CTRL, 16'd0, 8'h01);
    event_in = 1'b0;
    rd(A_CTRL, 16'd0, rd_val); chk("arm_status", 64'(rd_val), 64'h01);
    repeat (3) tick();
    chk("arm_evt_ignored_trig", 64'(trigger_out), 64'h0);
    rd(A_CTRL, 16'd0, rd_val); chk("arm_still_armed", 64'(rd_val), 64'h01);
    fire_event();
    capture(20, -1);
    chk("single_trig", tr_trig, 64'h1C00);
    chk("single_busy", tr_busy, 64'h1FFF);
    chk("single_done", tr_done, 64'hFE000);
    rd(A_CTRL, 16'd0, rd_val); chk("single_status", 64'(rd_val), 64'h04);

    // Pulse train, extra event mid-train ignored
    wr(A_DELAY, 16'd0, 8'd0);
    wr(A_WIDTH, 16'd0, 8'd2);
    wr(A_COUNT, 16'd0, 8'd3);
    wr(A_GAP, 16'd0, 8'd4);
    wr(A_CTRL, 16'd0, 8'h01);
    rd(A_CTRL, 16'd0, rd_val); chk("rearm_clears_done", 64'(rd_val), 64'h01);
    fire_event();
    capture(20, 4);
    chk("train_trig", tr_trig, 64'h30C3);
    chk("train_busy", tr_busy, 64'h3FFF);
    chk("train_done", tr_done, 64'hFC000);

    // Zero WIDTH/COUNT/GAP behave as 1
    wr(A_WIDTH, 16'd0, 8'd0);
    wr(A_COUNT, 16'd0, 8'd0);
    wr(A_GAP, 16'd0, 8'd0);
    wr(A_CTRL, 16'd0, 8'h01);
    fire_event();
    capture(8, -1);
    chk("zero_trig", tr_trig, 64'h01);
    chk("zero_busy", tr_busy, 64'h01);
    chk("zero_done", tr_done, 64'hFE);

    // Abort during PULSE, then an unarmed event does nothing
    wr(A_DELAY, 16'd0, 8'd2);
    wr(A_WIDTH, 16'd0, 8'd5);
    wr(A_COUNT, 16'd0, 8'd1);
    wr(A_CTRL, 16'd0, 8'h01);
    fire_event();
    repeat (2) tick();
    chk("abort_pre_trig", 64'(trigger_out), 64'h1);
    chk("abort_pre_state", 64'(dbg_state), 64'h3);
    wr(A_CTRL, 16'd0, 8'h02);
    chk("abort_trig", 64'(trigger_out), 64'h0);
    chk("abort_state", 64'(dbg_state), 64'h0);
    rd(A_CTRL, 16'd0, rd_val); chk("abort_status", 64'(rd_val), 64'h00);
    capture(10, 0);
    chk("abort_noevt_trig", tr_trig, 64'h0);

    // ARM and ABORT in one byte: ABORT wins
    wr(A_CTRL, 16'd0, 8'h03);
    chk("armabort_state", 64'(dbg_state), 64'h0);
    rd(A_CTRL, 16'd0, rd_val); chk("armabort_status", 64'(rd_val), 64'h00);
    capture(6, 0);
    chk("armabort_trig", tr_trig, 64'h0);

    // ARM while busy is ignored and not queued
    wr(A_DELAY, 16'd0, 8'd0);
    wr(A_WIDTH, 16'd0, 8'd3);
    wr(A_COUNT, 16'd0, 8'd2);
    wr(A_GAP, 16'd0, 8'd2);
    wr(A_CTRL, 16'd0, 8'h01);
    fire_event();
    chk("busyarm_trig_e1", 64'(trigger_out), 64'h1);
    wr(A_CTRL, 16'd0, 8'h01);
    rd(A_CTRL, 16'd0, rd_val); chk("busyarm_status", 64'(rd_val), 64'h02);
    capture(12, -1);
    chk("busyarm_trig", tr_trig, 64'h73);
    chk("busyarm_done", tr_done, 64'hF80);
    rd(A_CTRL, 16'd0, rd_val); chk("busyarm_end_status", 64'(rd_val), 64'h04);

    // Shadowing: DELAY rewritten mid-sequence affects only the next run
    wr(A_DELAY, 16'd0, 8'd20);
    wr(A_WIDTH, 16'd0, 8'd1);
    wr(A_COUNT, 16'd0, 8'd1);
    wr(A_CTRL, 16'd0, 8'h01);
    fire_event();
    wr(A_DELAY, 16'd0, 8'd50);
    rd(A_DELAY, 16'd0, rd_val); chk("shadow_readback", 64'(rd_val), 64'h32);
    capture(24, -1);
    chk("shadow_trig_20", tr_trig, 64'h80000);
    wr(A_CTRL, 16'd0, 8'h01);
    fire_event();
    capture(56, -1);
    chk("shadow_trig_50", tr_trig, 64'h0004000000000000);

    // Reset mid-sequence restores all defaults
    wr(A_DELAY, 16'd0, 8'd0);
    wr(A_WIDTH, 16'd0, 8'd8);
    wr(A_CTRL, 16'd0, 8'h01);
    fire_event();
    chk("midrst_pre_trig", 64'(trigger_out), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_trig", 64'(trigger_out), 64'h0);
    chk("midrst_state", 64'(dbg_state), 64'h0);
    rd(A_CTRL, 16'd0, rd_val);  chk("midrst_status", 64'(rd_val), 64'h00);
    rd(A_WIDTH, 16'd0, rd_val); chk("midrst_width", 64'(rd_val), 64'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
